// File: rtl/hub75_linebuffer_ring.sv
// Multi-bank HUB75 line buffer: writer fills and commits lines, reader consumes them in fill order.
// Optional bank scrub on release is enabled by defining HUB75_LB_CLEAR_EN.
module hub75_linebuffer_ring #(
  parameter int N_BANKS    = 2,
  parameter int N_WORDS    = 1,
  parameter int WORD_WIDTH = 24,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [N_WORDS*WORD_WIDTH-1:0] wr_data,
  input  logic [N_WORDS-1:0]            wr_mask,
  input  logic                          wr_ena,
  input  logic                          wr_done,
  output logic                          wr_rdy,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic                          rd_ena,
  output logic [N_WORDS*WORD_WIDTH-1:0] rd_data,
  output logic                          rd_valid,
  input  logic                          rd_done,
  output logic                          rd_rdy,
  output logic                          clr_busy
);

  localparam int PTR_W = $clog2(N_BANKS);
  localparam int CNT_W = $clog2(N_BANKS + 1);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int IDX_W = PTR_W + ADDR_WIDTH;
  localparam int DW    = N_WORDS * WORD_WIDTH;

  logic [N_WORDS-1:0][WORD_WIDTH-1:0] mem_r [N_BANKS*DEPTH];

  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [CNT_W-1:0] count_r;
  logic [DW-1:0]    rd_data_r;
  logic             rd_valid_r;

  logic             busy_s;
  logic             wr_rdy_s;
  logic             rd_rdy_s;
  logic             wr_acc_s;
  logic             commit_s;
  logic             release_s;
  logic             cnt_inc_s;
  logic             cnt_dec_s;
  logic             mem_we_s;
  logic [IDX_W-1:0] mem_widx_s;
  logic [N_WORDS-1:0] mem_wmask_s;
  logic [DW-1:0]    mem_wdata_s;

  assign wr_rdy_s  = (count_r < CNT_W'(N_BANKS)) & ~busy_s;
  assign rd_rdy_s  = (count_r != {CNT_W{1'b0}}) & ~busy_s;
  assign wr_acc_s  = wr_ena & wr_rdy_s;
  assign commit_s  = wr_done & wr_rdy_s;
  assign release_s = rd_done & rd_rdy_s;
  assign cnt_inc_s = commit_s;

`ifdef HUB75_LB_CLEAR_EN
  logic                  clr_busy_r;
  logic [ADDR_WIDTH-1:0] clr_addr_r;
  logic [PTR_W-1:0]      clr_bank_r;

  assign busy_s    = clr_busy_r;
  // A released bank is only handed back to the writer once its last entry is zeroed.
  assign cnt_dec_s = clr_busy_r & (clr_addr_r == ADDR_WIDTH'(DEPTH - 1));

  // Scrub sequencer: walks every entry of the released bank once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_busy_r <= 1'b0;
      clr_addr_r <= {ADDR_WIDTH{1'b0}};
      clr_bank_r <= {PTR_W{1'b0}};
    end else if (clr_busy_r) begin
      clr_addr_r <= clr_addr_r + ADDR_WIDTH'(1);
      if (clr_addr_r == ADDR_WIDTH'(DEPTH - 1)) begin
        clr_busy_r <= 1'b0;
      end
    end else if (release_s) begin
      clr_busy_r <= 1'b1;
      clr_addr_r <= {ADDR_WIDTH{1'b0}};
      clr_bank_r <= rptr_r;
    end
  end

  // Storage write port: scrub owns it while busy, otherwise the user writer.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_widx_s  = {wptr_r, wr_addr};
    mem_wmask_s = wr_mask;
    mem_wdata_s = wr_data;
    if (clr_busy_r) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = {clr_bank_r, clr_addr_r};
      mem_wmask_s = {N_WORDS{1'b1}};
      mem_wdata_s = {DW{1'b0}};
    end else begin
      mem_we_s    = wr_acc_s;
    end
  end
`else
  assign busy_s      = 1'b0;
  assign cnt_dec_s   = release_s;
  assign mem_we_s    = wr_acc_s;
  assign mem_widx_s  = {wptr_r, wr_addr};
  assign mem_wmask_s = wr_mask;
  assign mem_wdata_s = wr_data;
`endif

  // Bank pointers and fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (commit_s) begin
        wptr_r <= wptr_r + PTR_W'(1);
      end
      if (release_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      case ({cnt_inc_s, cnt_dec_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered read port; the nonblocking read returns pre-write contents on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= {DW{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_ena & rd_rdy_s;
      if (rd_ena) begin
        rd_data_r <= mem_r[{rptr_r, rd_addr}];
      end
    end
  end

  // Line storage with per-word write enables; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (mem_wmask_s[i]) begin
          mem_r[mem_widx_s][i] <= mem_wdata_s[i*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

  assign wr_rdy   = wr_rdy_s;
  assign rd_rdy   = rd_rdy_s;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign clr_busy = busy_s;

endmodule

// File: tb/tb_hub75_linebuffer_ring.sv
// Scoreboard bench for hub75_linebuffer_ring (2 banks, 2 words of 8 bits, 8 entries).
module tb_hub75_linebuffer_ring;

  localparam int NB = 2;
  localparam int NW = 2;
  localparam int WW = 8;
  localparam int AW = 3;
  localparam int DW = NW * WW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NW-1:0] wr_mask = '0;
  logic          wr_ena = 1'b0;
  logic          wr_done = 1'b0;
  logic          wr_rdy;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ena = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_done = 1'b0;
  logic          rd_rdy;
  logic          clr_busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  hub75_linebuffer_ring #(
    .N_BANKS(NB), .N_WORDS(NW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_ena(wr_ena),
    .wr_done(wr_done), .wr_rdy(wr_rdy),
    .rd_addr(rd_addr), .rd_ena(rd_ena), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_done(rd_done), .rd_rdy(rd_rdy), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NW-1:0] m);
    wr_addr = a; wr_data = d; wr_mask = m; wr_ena = 1'b1;
    cyc();
    wr_ena = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    exp_q.push_back(e);
    rd_addr = a; rd_ena = 1'b1;
    cyc();
    rd_ena = 1'b0;
  endtask

  task automatic wdone();
    wr_done = 1'b1; cyc(); wr_done = 1'b0;
  endtask

  task automatic rdone();
    rd_done = 1'b1; cyc(); rd_done = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && clr_busy; k++) cyc();
    check_eq("scrub_timeout", clr_busy, 0);
  endtask

  // Scoreboard: every valid read must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) check_eq("rd_unexpected", rd_valid, 0);
      else check_eq("rd_data", rd_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a8;
    int n;
    cyc(); cyc();
    check_eq("rst_wr_rdy", wr_rdy, 1);
    check_eq("rst_rd_rdy", rd_rdy, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_clr_busy", clr_busy, 0);
    rst_n = 1'b1;
    cyc();

    // Line 0 into bank 0.
    for (int a = 0; a < 8; a++) begin
      a8 = 8'(a);
      wr(AW'(a), {8'hA0 + a8, 8'h50 + a8}, 2'b11);
    end
    check_eq("pre_commit_rd_rdy", rd_rdy, 0);
    wdone();
    check_eq("commit1_rd_rdy", rd_rdy, 1);
    check_eq("commit1_wr_rdy", wr_rdy, 1);
    rd(3'd5, 16'hA555);

    // Line 1 into bank 1 with masked overwrites.
    for (int a = 0; a < 8; a++) begin
      a8 = 8'(a);
      wr(AW'(a), {8'hB0 + a8, 8'h60 + a8}, 2'b11);
    end
    wr(3'd5, 16'hA555, 2'b11);
    wr(3'd5, 16'h1234, 2'b01);
    wr(3'd6, 16'h1234, 2'b10);
    wr(3'd7, 16'h1234, 2'b00);
    wdone();
    check_eq("full_wr_rdy", wr_rdy, 0);
    check_eq("full_rd_rdy", rd_rdy, 1);
    wr(3'd0, 16'hFFFF, 2'b11);
    rd(3'd0, 16'hA050);
    rd(3'd7, 16'hA757);
    rdone();
`ifndef HUB75_LB_CLEAR_EN
    check_eq("release_wr_rdy", wr_rdy, 1);
`endif
    wait_idle();
    check_eq("release_rd_rdy", rd_rdy, 1);
    check_eq("release_wr_rdy2", wr_rdy, 1);
    rd(3'd5, 16'hA534);
    rd(3'd6, 16'h1266);
    rd(3'd7, 16'hB767);
    rd(3'd0, 16'hB060);

    // Simultaneous commit and release at count 1.
    wr(3'd3, 16'hC373, 2'b11);
    wr_done = 1'b1; rd_done = 1'b1;
    cyc();
    wr_done = 1'b0; rd_done = 1'b0;
    wait_idle();
    check_eq("simul_rd_rdy", rd_rdy, 1);
    check_eq("simul_wr_rdy", wr_rdy, 1);
    rd(3'd3, 16'hC373);
    wr(3'd2, 16'hD2D2, 2'b11);
    wdone();
    check_eq("simul_full_wr_rdy", wr_rdy, 0);
    rdone();
    wait_idle();
    rd(3'd2, 16'hD2D2);

    // Drain to empty, then ignored strobes.
    rdone();
    wait_idle();
    check_eq("empty_rd_rdy", rd_rdy, 0);
    rdone();
    check_eq("empty_rd_done_busy", clr_busy, 0);
    check_eq("empty_rd_done_rdy", rd_rdy, 0);
    check_eq("empty_wr_rdy", wr_rdy, 1);
    rd_addr = 3'd0; rd_ena = 1'b1; cyc(); rd_ena = 1'b0;
    check_eq("empty_rd_valid", rd_valid, 0);

    // Bank 0 all ones, bank 1 one marker, then wr_done while full.
    for (int a = 0; a < 8; a++) wr(AW'(a), 16'hFFFF, 2'b11);
    wdone();
    wr(3'd1, 16'h1111, 2'b11);
    wdone();
    wdone();
    check_eq("ign_wr_rdy", wr_rdy, 0);
    rd(3'd4, 16'hFFFF);
    rdone();
`ifdef HUB75_LB_CLEAR_EN
    n = 0;
    while (clr_busy && n < 20) begin
      check_eq("scrub_rd_rdy", rd_rdy, 0);
      check_eq("scrub_wr_rdy", wr_rdy, 0);
      n++;
      cyc();
    end
    check_eq("scrub_len", n, 8);
`endif
    wait_idle();
    check_eq("ign_after_wr_rdy", wr_rdy, 1);
    check_eq("ign_after_rd_rdy", rd_rdy, 1);
    rd(3'd1, 16'h1111);
`ifdef HUB75_LB_CLEAR_EN
    wdone();
    rdone();
    wait_idle();
    for (int a = 0; a < 8; a++) rd(AW'(a), 16'h0000);
`endif

    // Asynchronous reset while a read is valid.
    rd_addr = 3'd1; rd_ena = 1'b1; cyc(); rd_ena = 1'b0;
    check_eq("pre_rst_rd_valid", rd_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_rd_valid", rd_valid, 0);
    check_eq("arst_rd_data", rd_data, 0);
    check_eq("arst_rd_rdy", rd_rdy, 0);
    check_eq("arst_wr_rdy", wr_rdy, 1);
    check_eq("arst_clr_busy", clr_busy, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check_eq("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_linebuffer_ring.md
Name: hub75_linebuffer_ring

Overview:
Multi-bank line buffer for the HUB75 panel path. Holds N_BANKS lines of 2^ADDR_WIDTH entries, each entry N_WORDS words of WORD_WIDTH bits.
- Writer (framebuffer/fetch side) fills one line at a time with per-word write masks.
- Reader (scan/shift side) consumes full lines in fill order.
- A fill counter with a writer/reader handshake replaces external bank bookkeeping.

Parameters:
N_BANKS, 2, number of line banks; power of two, >= 2
N_WORDS, 1, words per entry (one per panel half/channel)
WORD_WIDTH, 24, bits per word
ADDR_WIDTH, 6, entry address width; 2^ADDR_WIDTH entries per bank

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_addr  in  ADDR_WIDTH  entry address within current write bank
wr_data  in  N_WORDS*WORD_WIDTH  write data; word i at bits [(i+1)*WORD_WIDTH-1 -: WORD_WIDTH]
wr_mask  in  N_WORDS  per-word write enable
wr_ena  in  1  write strobe
wr_done  in  1  pulse: current write bank complete, commit it
wr_rdy  out  1  writer owns a free bank
rd_addr  in  ADDR_WIDTH  entry address within current read bank
rd_ena  in  1  read strobe
rd_data  out  N_WORDS*WORD_WIDTH  registered read data
rd_valid  out  1  rd_data holds a valid read of a committed line
rd_done  in  1  pulse: current read bank consumed, release it
rd_rdy  out  1  reader owns a committed bank
clr_busy  out  1  bank scrub in progress (0 when feature compiled out)

Behaviour:
- Storage: N_BANKS*2^ADDR_WIDTH entries, indexed {bank_ptr, addr}. No reset of storage contents.
- State: wptr and rptr (log2(N_BANKS) bits, wrap modulo N_BANKS) and fill count (0..N_BANKS).
- Reset (async, rst_n=0): wptr=rptr=count=0, rd_data=0, rd_valid=0, clr_busy=0. Resulting outputs: wr_rdy=1, rd_rdy=0.
- wr_rdy = (count < N_BANKS) & ~clr_busy. rd_rdy = (count != 0) & ~clr_busy. Both are combinational from registered state.
- Write: wr_ena & wr_rdy writes each word i with wr_mask[i]=1 into {wptr, wr_addr}. Unmasked words are unchanged. Writes with wr_rdy=0 are dropped.
- Commit: wr_done & wr_rdy sets wptr<=wptr+1 and count<=count+1. A write in the same cycle lands in the old bank. wr_done with wr_rdy=0 is ignored.
- Read: rd_ena reads {rptr, rd_addr} into rd_data next cycle (latency 1).
  - rd_valid <= rd_ena & rd_rdy.
  - With rd_ena=0, rd_data holds its value and rd_valid <= 0.
  - Reads with rd_rdy=0 still update rd_data (contents unspecified) but rd_valid=0.
- Release: rd_done & rd_rdy sets rptr<=rptr+1 and count<=count-1 (feature off). A read in the same cycle uses the old rptr. rd_done with rd_rdy=0 is ignored.
- Simultaneous accepted wr_done and rd_done: both pointers advance, count unchanged.
- Read/write same entry, same cycle: rd_data returns the OLD contents (read-before-write).
- Full (count=N_BANKS): writer stalls; reader unaffected. Empty (count=0): reader stalls.

Optional Feature:
HUB75_LB_CLEAR_EN
- Defined: an accepted rd_done starts a scrub of the released bank.
  - rptr advances immediately.
  - clr_busy=1 for exactly 2^ADDR_WIDTH cycles, writing all-zero to addresses 0..2^ADDR_WIDTH-1 of the released bank, one per cycle, via the write port.
  - count decrements on the last scrub cycle; clr_busy falls the cycle after.
  - During the scrub, wr_rdy=rd_rdy=0: user writes, wr_done and rd_done are dropped, and rd_valid=0.
  - rst_n low mid-scrub aborts it: clr_busy=0 and the bank is left partially cleared.
- Undefined: no scrub logic, clr_busy tied 0, and released banks keep stale data.

Test Plan:
All scenarios use N_BANKS=2, N_WORDS=2, WORD_WIDTH=8, ADDR_WIDTH=3.
1. Reset, then write addr 0..7 with data {8'hA0+a, 8'h50+a}, mask 2'b11, then wr_done -> rd_rdy=1; rd_ena at addr 5 -> next cycle rd_data=16'hA555, rd_valid=1.
2. Masked write: bank contents 16'hA555 at addr 5, write 16'h1234 with mask 2'b01 -> read returns 16'hA534.
3. Commit two lines without rd_done -> wr_rdy=0; third-line writes to addr 0 are dropped; rd_done -> wr_rdy=1 next cycle; second read bank returns the second line's data.
4. Simultaneous wr_done and rd_done with count=1 -> count stays 1, both pointers toggle, and rd_rdy/wr_rdy stay 1.
5. rd_done at count=0 or wr_done at count=2 -> ignored, no pointer or count change; assert rst_n low mid-sequence -> all outputs return to reset values asynchronously, before the next clock edge.
6. (HUB75_LB_CLEAR_EN) rd_done on a bank holding 16'hFFFF at every entry -> clr_busy high for 8 cycles, rd_rdy=wr_rdy=0 meanwhile; re-commit the bank unwritten -> reads return 16'h0000 at all 8 addresses.
